// File: rtl/frame_scanner.sv
// frame_scanner: ingress parse stage ahead of the request buffer.
// Forwards the 16-bit word stream with one cycle of latency. Each forwarded
// beat carries the frame scan status, the drop decision and the destination
// port. Saturating counters track completed and dropped frames.
module frame_scanner #(
  parameter int HEADER_WORDS    = 7,
  parameter int DEST_WIDTH      = 2,
  parameter int MAX_FRAME_WORDS = 759,
  parameter int CTR_WIDTH       = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [15:0]           in_data,
  input  logic                  in_last,
  input  logic                  cfg_drop_en,
  input  logic [15:0]           cfg_drop_ethertype,
  input  logic                  almost_full,
  output logic                  out_valid,
  output logic [15:0]           out_data,
  output logic                  out_last,
  output logic                  scan_frame,
  output logic                  scan_payload,
  output logic                  frame_drop,
  output logic [DEST_WIDTH-1:0] frame_dest,
  output logic [15:0]           frames_seen,
  output logic [15:0]           frames_dropped
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    DISCARD = 2'd3
  } state_t;

  // Word positions inside the header that carry parse information.
  localparam logic [CTR_WIDTH-1:0] IDX_SAT  = '1;
  localparam logic [CTR_WIDTH-1:0] HDR_LEN  = CTR_WIDTH'(HEADER_WORDS);
  localparam logic [CTR_WIDTH-1:0] DEST_IDX = CTR_WIDTH'(2);
  localparam logic [CTR_WIDTH-1:0] ETH_IDX  = CTR_WIDTH'(HEADER_WORDS - 1);
  localparam logic [CTR_WIDTH-1:0] OVER_IDX = CTR_WIDTH'(MAX_FRAME_WORDS);
  localparam logic [15:0]          CNT_SAT  = 16'hFFFF;

  state_t                  state_q;
  state_t                  state_nxt;
  logic [CTR_WIDTH-1:0]    idx_q;
  logic [CTR_WIDTH-1:0]    idx_inc;
  logic [DEST_WIDTH-1:0]   dest_q;
  logic [DEST_WIDTH-1:0]   dest_nxt;
  logic                    eth_q;
  logic                    eth_nxt;
  logic                    over_q;
  logic                    over_nxt;
  logic                    beat_discard;
  logic                    beat_drop;
  logic [DEST_WIDTH-1:0]   beat_dest;

  // Per-beat parse decision: status to register for the current input word.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_nxt    = state_q;
    dest_nxt     = dest_q;
    eth_nxt      = eth_q;
    over_nxt     = over_q;
    beat_drop    = 1'b0;
    beat_dest    = '0;
    idx_inc      = (idx_q == IDX_SAT) ? idx_q : idx_q + 1'b1;

    // almost_full only matters on the first word of a frame.
    beat_discard = (state_q == DISCARD) || ((state_q == IDLE) && almost_full);

    if (idx_q == DEST_IDX) begin
      dest_nxt = in_data[DEST_WIDTH-1:0];
    end
    if ((idx_q == ETH_IDX) && cfg_drop_en && (in_data == cfg_drop_ethertype)) begin
      eth_nxt = 1'b1;
    end
    if (idx_q == OVER_IDX) begin
      over_nxt = 1'b1;
    end

    if (beat_discard) begin
      beat_drop = 1'b1;
      beat_dest = '0;
    end else if (idx_q < HDR_LEN) begin
      // Header words show no verdict yet; a last word here makes a runt.
      beat_drop = in_last;
      beat_dest = '0;
    end else begin
      beat_drop = eth_nxt | over_nxt;
      beat_dest = dest_nxt;
    end

    if (in_last) begin
      state_nxt = IDLE;
    end else if (beat_discard) begin
      state_nxt = DISCARD;
    end else if (idx_q >= HDR_LEN) begin
      state_nxt = PAYLOAD;
    end else begin
      state_nxt = HEADER;
    end
  end

  // Frame state, registered outputs and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q        <= IDLE;
      idx_q          <= '0;
      dest_q         <= '0;
      eth_q          <= 1'b0;
      over_q         <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_last       <= 1'b0;
      scan_frame     <= 1'b0;
      scan_payload   <= 1'b0;
      frame_drop     <= 1'b0;
      frame_dest     <= '0;
      frames_seen    <= '0;
      frames_dropped <= '0;
    end else begin
      out_valid <= in_valid;
      out_data  <= in_data;
      out_last  <= in_valid & in_last;

      if (in_valid) begin
        scan_frame   <= 1'b1;
        scan_payload <= (idx_q >= HDR_LEN);
        frame_drop   <= beat_drop;
        frame_dest   <= beat_dest;
        state_q      <= state_nxt;

        if (in_last) begin
          // Frame ends: count it and clear per-frame state for the next one.
          idx_q  <= '0;
          dest_q <= '0;
          eth_q  <= 1'b0;
          over_q <= 1'b0;
          if (frames_seen != CNT_SAT) begin
            frames_seen <= frames_seen + 16'd1;
          end
          if (beat_drop && (frames_dropped != CNT_SAT)) begin
            frames_dropped <= frames_dropped + 16'd1;
          end
        end else begin
          idx_q  <= idx_inc;
          dest_q <= dest_nxt;
          eth_q  <= eth_nxt;
          over_q <= over_nxt;
        end
      end else if (state_q == IDLE) begin
        // Between frames the status drops; inside a frame it holds across gaps.
        scan_frame   <= 1'b0;
        scan_payload <= 1'b0;
        frame_drop   <= 1'b0;
        frame_dest   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_frame_scanner.sv
// tb_frame_scanner: directed frames with literal expectations followed by
// randomized frames, all checked every cycle against a frame-level model.
module tb_frame_scanner;

  localparam int HW   = 7;
  localparam int DW   = 2;
  localparam int MAXW = 759;
  localparam int CW   = 11;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [15:0]   in_data;
  logic          in_last;
  logic          cfg_drop_en;
  logic [15:0]   cfg_drop_ethertype;
  logic          almost_full;
  logic          out_valid;
  logic [15:0]   out_data;
  logic          out_last;
  logic          scan_frame;
  logic          scan_payload;
  logic          frame_drop;
  logic [DW-1:0] frame_dest;
  logic [15:0]   frames_seen;
  logic [15:0]   frames_dropped;

  int checks = 0;
  int errors = 0;

  frame_scanner #(
    .HEADER_WORDS(HW), .DEST_WIDTH(DW), .MAX_FRAME_WORDS(MAXW), .CTR_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .cfg_drop_en(cfg_drop_en),
    .cfg_drop_ethertype(cfg_drop_ethertype), .almost_full(almost_full),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .scan_frame(scan_frame), .scan_payload(scan_payload),
    .frame_drop(frame_drop), .frame_dest(frame_dest),
    .frames_seen(frames_seen), .frames_dropped(frames_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Frame-level bookkeeping: where we are in the frame and what it learned.
  bit       m_in_frame;
  int       m_idx;
  bit       m_discard;
  int       m_dest;
  bit       m_eth;
  bit       m_over;
  int       m_seen;
  int       m_dropped;
  bit       e_valid, e_last, e_frame, e_payload, e_drop;
  int       e_data, e_dest;

  always @(posedge clk) begin
    if (reset) begin
      m_in_frame = 0; m_idx = 0; m_discard = 0; m_dest = 0; m_eth = 0; m_over = 0;
      m_seen = 0; m_dropped = 0;
      e_valid = 0; e_last = 0; e_frame = 0; e_payload = 0; e_drop = 0; e_data = 0; e_dest = 0;
    end else if (in_valid) begin
      if (m_idx == 0) m_discard = almost_full;
      if (m_idx == 2) m_dest = int'(in_data) % (1 << DW);
      if (m_idx == 6 && cfg_drop_en && in_data == cfg_drop_ethertype) m_eth = 1;
      if (m_idx == MAXW) m_over = 1;
      e_valid   = 1;
      e_data    = int'(in_data);
      e_last    = in_last;
      e_frame   = 1;
      e_payload = (m_idx >= HW);
      if (m_discard) begin
        e_drop = 1; e_dest = 0;
      end else if (m_idx < HW) begin
        e_drop = in_last; e_dest = 0;
      end else begin
        e_drop = m_eth | m_over; e_dest = m_dest;
      end
      if (in_last) begin
        if (m_seen < 65535) m_seen++;
        if (e_drop && m_dropped < 65535) m_dropped++;
        m_in_frame = 0; m_idx = 0; m_discard = 0; m_dest = 0; m_eth = 0; m_over = 0;
      end else begin
        m_in_frame = 1;
        m_idx = (m_idx + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_idx + 1;
      end
    end else begin
      e_valid = 0;
      e_last  = 0;
      if (!m_in_frame) begin
        e_frame = 0; e_payload = 0; e_drop = 0; e_dest = 0;
      end
    end
    // Compare one time unit after the edge, once the DUT registers settle.
    #1;
    check("out_valid", out_valid, e_valid);
    check("out_last", out_last, e_last);
    if (e_valid) check("out_data", out_data, e_data);
    check("scan_frame", scan_frame, e_frame);
    check("scan_payload", scan_payload, e_payload);
    check("frame_drop", frame_drop, e_drop);
    check("frame_dest", frame_dest, e_dest);
    check("frames_seen", frames_seen, m_seen);
    check("frames_dropped", frames_dropped, m_dropped);
  end

  // ---------------- stimulus helpers ----------------
  task automatic beat(input logic [15:0] d, input logic l, input logic af);
    in_valid    = 1'b1;
    in_data     = d;
    in_last     = l;
    almost_full = af;
    @(negedge clk);
    in_valid    = 1'b0;
    in_last     = 1'b0;
    in_data     = 16'($urandom);
    almost_full = 1'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Simple frame with the given dest word2 and ethertype word6.
  task automatic send_frame(input int len, input logic [15:0] w2, input logic [15:0] w6,
                            input logic af0, input int gap_pct);
    for (int i = 0; i < len; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if (i == 2) d = w2;
      if (i == 6) d = w6;
      beat(d, (i == len - 1), (i == 0) ? af0 : 1'($urandom));
      if (i != len - 1 && int'($urandom_range(99, 0)) < gap_pct) idle(int'($urandom_range(3, 1)));
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    cfg_drop_en = 1'b0; cfg_drop_ethertype = 16'h0800; almost_full = 1'b0;
    idle(3);
    reset = 1'b0;
    check("reset frames_seen", frames_seen, 0);
    check("reset scan_frame", scan_frame, 0);

    // 10-word frame, no drop rule.
    for (int i = 0; i < 10; i++) begin
      beat((i == 2) ? 16'h0003 : (i == 6) ? 16'h0800 : 16'h1000 + 16'(i), i == 9, 1'b0);
      if (i == 6) check("hdr beat6 payload", scan_payload, 0);
      if (i == 7) check("beat7 payload", scan_payload, 1);
    end
    check("f1 last", out_last, 1);
    check("f1 dest", frame_dest, 3);
    check("f1 drop", frame_drop, 0);
    check("f1 seen", frames_seen, 1);
    idle(2);

    // Same frame with the ethertype drop rule enabled.
    cfg_drop_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      beat((i == 2) ? 16'h0003 : (i == 6) ? 16'h0800 : 16'h2000 + 16'(i), i == 9, 1'b0);
      if (i == 6) check("f2 hdr drop", frame_drop, 0);
      if (i == 7) check("f2 beat7 drop", frame_drop, 1);
    end
    check("f2 dropped", frames_dropped, 1);
    cfg_drop_en = 1'b0;

    // 4-word runt, back to back.
    for (int i = 0; i < 4; i++) begin
      beat(16'h3000 + 16'(i), i == 3, 1'b0);
      if (i == 2) check("runt beat2 drop", frame_drop, 0);
    end
    check("runt drop", frame_drop, 1);
    check("runt dropped", frames_dropped, 2);

    // almost_full on the first word: whole frame discarded.
    for (int i = 0; i < 12; i++) begin
      beat((i == 2) ? 16'h0002 : 16'h4000 + 16'(i), i == 11, i == 0);
      if (i == 8) check("discard dest", frame_dest, 0);
    end
    check("discard drop", frame_drop, 1);
    check("discard dropped", frames_dropped, 3);

    // 800-word oversize frame.
    for (int i = 0; i < 800; i++) begin
      beat((i == 2) ? 16'h0001 : 16'(i), i == 799, 1'b0);
      if (i == 758) check("over beat758", frame_drop, 0);
      if (i == 759) check("over beat759", frame_drop, 1);
    end
    check("over last drop", frame_drop, 1);
    check("over dest", frame_dest, 1);
    check("over seen", frames_seen, 5);

    // Reset in the middle of a frame.
    for (int i = 0; i < 6; i++) beat(16'h5000 + 16'(i), 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid reset frame", scan_frame, 0);
    check("mid reset seen", frames_seen, 0);
    send_frame(8, 16'h0002, 16'h86DD, 1'b0, 0);
    check("post reset seen", frames_seen, 1);
    check("post reset dest", frame_dest, 2);

    // Randomized frames with gaps, drop rule and back-pressure.
    for (int f = 0; f < 80; f++) begin
      cfg_drop_en        = 1'($urandom);
      cfg_drop_ethertype = ($urandom_range(1, 0) == 1) ? 16'h0800 : 16'h86DD;
      send_frame(int'($urandom_range(20, 1)), 16'($urandom), ($urandom_range(1, 0) == 1) ? 16'h0800 : 16'h86DD,
                 ($urandom_range(9, 0) == 0), 25);
      if ($urandom_range(1, 0) == 1) idle(int'($urandom_range(3, 1)));
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_scanner.md
# frame_scanner

Ingress parse stage directly upstream of the request buffer. It consumes the raw 16-bit ingress word stream and forwards it with one cycle of latency. Alongside each forwarded beat it produces the per-frame scan status (frame/payload phase), the drop decision and the destination port that the request buffer stores as sideband. It also keeps saturating frame and drop statistics.

## Interface
Parameters:
- HEADER_WORDS, 7, header length in 16-bit words (dest MAC 3, src MAC 3, ethertype 1).
- DEST_WIDTH, 2, width of destination port index.
- MAX_FRAME_WORDS, 759, largest legal frame in words; longer frames are dropped.
- CTR_WIDTH, 11, word-index counter width; saturates at all-ones.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  ingress beat valid.
- in_data  in  16  ingress word; first byte on wire in [15:8].
- in_last  in  1  final beat of frame.
- cfg_drop_en  in  1  enable ethertype drop rule.
- cfg_drop_ethertype  in  16  ethertype to drop.
- almost_full  in  1  back-pressure from request buffer.
- out_valid  out  1  registered in_valid.
- out_data  out  16  registered in_data.
- out_last  out  1  registered in_last.
- scan_frame  out  1  frame in progress.
- scan_payload  out  1  payload phase.
- frame_drop  out  1  current frame is to be dropped.
- frame_dest  out  DEST_WIDTH  destination port of current frame.
- frames_seen  out  16  saturating count of completed frames.
- frames_dropped  out  16  saturating count of dropped frames.

## Operation
- States: IDLE, HEADER, PAYLOAD, DISCARD. Word index idx is counted on accepted beats and restarts at 0 for each frame. A beat is accepted whenever in_valid=1; there is no ready signal.
- IDLE, accepted beat with idx=0:
  - If almost_full=1, go to DISCARD and set frame_drop sticky.
  - Otherwise go to HEADER.
  - If in_last=1 on this same beat, return to IDLE after the beat. The frame is a runt (drop).
- HEADER:
  - Capture frame_dest from in_data[DEST_WIDTH-1:0] at idx=2, i.e. the last dest-MAC byte.
  - At idx=6, compare in_data to cfg_drop_ethertype. If cfg_drop_en=1 and the values are equal, set frame_drop.
  - The beat with idx=HEADER_WORDS moves the state to PAYLOAD.
- in_last before idx reaches HEADER_WORDS-1, or on idx=HEADER_WORDS-1 itself: runt frame. frame_drop is forced to 1 on that last beat.
- PAYLOAD: an accepted beat with idx=MAX_FRAME_WORDS is oversize. It sets frame_drop, sticky to frame end.
- DISCARD: consume beats until in_last. frame_drop=1 throughout and frame_dest=0.
- Any state, beat with in_last=1: go to IDLE. Clear frame_drop/frame_dest internal state for the next frame, after the outputs for this beat are registered.
- almost_full is sampled only on idx=0 beats.
- idx saturates at 2^CTR_WIDTH-1 and does not wrap.
- Counters on each out_last beat:
  - frames_seen increments by 1.
  - frames_dropped increments when frame_drop=1 on that beat.
  - Both stick at 16'hFFFF.

## Timing
- All outputs are registered. The beat accepted at cycle N appears on out_* at N+1, together with its status.
- scan_frame=1 on every output beat from idx 0 through last. It stays high across in_valid gaps inside a frame and drops to 0 the cycle after the out_last beat unless a new frame starts.
- scan_payload=1 on output beats with idx≥HEADER_WORDS, and holds through gaps.
- frame_drop and frame_dest are 0 on output beats idx 0..HEADER_WORDS-1, with these exceptions:
  - DISCARD or a runt beat shows frame_drop=1 immediately.
  - From idx=HEADER_WORDS on, both hold stable to the out_last beat. The only change allowed is frame_drop rising on an oversize beat.
- Back-to-back frames are legal: an in_last beat followed immediately by idx=0 of the next frame.
- Reset values: every output is 0; the state is IDLE and the counters are 0. Reset mid-frame abandons the frame without counting it, and the next valid beat is treated as idx=0.

## Test plan
- 10-word frame, dest word2=16'h0003, ethertype 16'h0800, cfg_drop_en=0 -> out beats 1 cycle late; scan_payload high on beats 7..9; frame_dest=3, frame_drop=0; frames_seen=1.
- Same frame with cfg_drop_en=1, cfg_drop_ethertype=16'h0800 -> frame_drop=1 on beats 7..9; frames_dropped=1.
- 4-word runt (in_last on idx 3) -> frame_drop=1 on out beat 3 only; scan_payload never high; frames_dropped increments.
- almost_full=1 on idx 0 of a 12-word frame, then deasserted -> frame_drop=1 on all 12 out beats, frame_dest=0; the next frame parses normally.
- 800-word frame -> frame_drop rises on out beat 759 and holds to last; two back-to-back 8-word frames with in_valid gaps -> scan_frame continuous within each frame, counters=+2.
- Reset asserted at idx 5 -> all outputs 0 next cycle; counters 0; a following 8-word frame is counted normally.
